joypad_shift: RTL and testbench

Responder side of the controller-port protocol: models two NES standard controllers (4021-style 8-bit parallel-in/serial-out registers) behind the APU's $4016/$4017 strobe and read-clock outputs. It takes raw parallel button states, synchronizes them, and loads them while the strobe is high. On each read-clock pulse it shifts one bit toward the serial data lines that the APU samples. It sits at the SoC top between the APU controller port and the board's button or host-bridge source.

---
 rtl/joypad_pkg.sv | 32 +++
 rtl/joypad_port.sv | 52 +++++
 rtl/joypad_shift.sv | 36 +++
 tb/tb_joypad_shift.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/joypad_pkg.sv
// Shared definitions for the NES controller-port responder: button bit
// positions, the button vector type and the D-pad legality filter.
package joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] joypad_buttons_t;

  // Opposing D-pad directions pressed together are physically impossible on
  // a real pad, so both directions of such a pair are reported as released.
  function automatic joypad_buttons_t dpad_filter(input joypad_buttons_t b);
    joypad_buttons_t r;
    r = b;
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      r[BTN_LEFT]  = 1'b0;
      r[BTN_RIGHT] = 1'b0;
    end
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      r[BTN_UP]   = 1'b0;
      r[BTN_DOWN] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/joypad_port.sv
// One controller port: button synchronizer, optional D-pad filter and the
// 4021-style shift register whose LSB is the serial bit the APU samples.
// Optional feature: JOYPAD_DPAD_FILTER_EN clears opposing D-pad pairs at load.
module joypad_port
  import joypad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic       rd_pulse,
  input  logic [7:0] buttons,
  output logic       ser_data
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  joypad_buttons_t             load_val;
  joypad_buttons_t             sr;

  // Bring the asynchronous button lines into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], buttons};
    end
  end

  // Select the value parallel-loaded while the strobe is high.
  always_comb begin
`ifdef JOYPAD_DPAD_FILTER_EN
    load_val = dpad_filter(sync_q[SYNC_STAGES-1]);
`else
    load_val = sync_q[SYNC_STAGES-1];
`endif
  end

  // Reload while strobed; otherwise shift toward bit 0 with ones filling in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (strobe) begin
      sr <= load_val;
    end else if (rd_pulse) begin
      sr <= {1'b1, sr[7:1]};
    end
  end

  assign ser_data = sr[0];

endmodule

// File: rtl/joypad_shift.sv
// Two NES standard controllers behind the APU $4016/$4017 strobe and read
// clocks. Both ports share the strobe; each has its own read clock.
// Optional feature: JOYPAD_DPAD_FILTER_EN (applied inside each port).
module joypad_shift
  import joypad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [1:0] rd_pulse,
  input  logic [7:0] buttons0,
  input  logic [7:0] buttons1,
  output logic [1:0] ser_data
);

  joypad_port #(.SYNC_STAGES(SYNC_STAGES)) u_port0 (
    .clk      (clk),
    .rst      (rst),
    .strobe   (strobe),
    .rd_pulse (rd_pulse[0]),
    .buttons  (buttons0),
    .ser_data (ser_data[0])
  );

  joypad_port #(.SYNC_STAGES(SYNC_STAGES)) u_port1 (
    .clk      (clk),
    .rst      (rst),
    .strobe   (strobe),
    .rd_pulse (rd_pulse[1]),
    .buttons  (buttons1),
    .ser_data (ser_data[1])
  );

endmodule

// File: tb/tb_joypad_shift.sv
// Directed bench for joypad_shift: reset, load/shift, strobe-held tracking,
// simultaneous ports, D-pad filter and asynchronous reset mid-shift.
module tb_joypad_shift;

  logic       clk;
  logic       rst;
  logic       strobe;
  logic [1:0] rd_pulse;
  logic [7:0] buttons0;
  logic [7:0] buttons1;
  logic [1:0] ser_data;

  int checks = 0;
  int errors = 0;

  joypad_shift #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .strobe   (strobe),
    .rd_pulse (rd_pulse),
    .buttons0 (buttons0),
    .buttons1 (buttons1),
    .ser_data (ser_data)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic stb, input logic [1:0] rd,
                               input logic [7:0] b0, input logic [7:0] b1);
    strobe   = stb;
    rd_pulse = rd;
    buttons0 = b0;
    buttons1 = b1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] expected);
    checks++;
    assert (ser_data === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, ser_data, expected);
    end
  endtask

  // Strobe for four clocks so the synchronized buttons are loaded, then drop it.
  task automatic loadButtons(input logic [7:0] b0, input logic [7:0] b1);
    applyStimulus(1'b1, 2'b00, b0, b1);
    repeat (4) step();
    strobe = 1'b0;
  endtask

  // Issue n reads; a pulsed port reports its loaded bit i, then ones after 8
  // reads; an idle port keeps its loaded bit 0.
  task automatic readSequence(input string tag, input logic [1:0] rd,
                              input logic [7:0] exp0, input logic [7:0] exp1,
                              input int n);
    logic e0, e1;
    for (int i = 0; i < n; i++) begin
      rd_pulse = rd;
      e0 = rd[0] ? ((i < 8) ? exp0[i] : 1'b1) : exp0[0];
      e1 = rd[1] ? ((i < 8) ? exp1[i] : 1'b1) : exp1[0];
      checkOutput($sformatf("%s_read%0d", tag, i), {e1, e0});
      step();
    end
    rd_pulse = 2'b00;
  endtask

  logic [2:0] a_hist;
  logic       a_now;
  logic [7:0] dpad_lr_exp;
  logic [7:0] dpad_ud_exp;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00);

    // Reset then idle
    #3;
    checkOutput("reset_early", 2'b00);
    repeat (3) step();
    checkOutput("reset_held", 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("idle%0d", i), 2'b00);
    end

    // Load and shift on port 0 only, including the ones fill
    loadButtons(8'b1000_0101, 8'h00);
    readSequence("load_shift", 2'b01, 8'b1000_0101, 8'h00, 10);

    // Strobe held high: A tracks with 3-clk latency, pulses have no effect
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00);
    repeat (4) step();
    a_hist = 3'b000;
    for (int k = 0; k < 40; k++) begin
      checkOutput($sformatf("strobe_high%0d", k), {1'b0, a_hist[2]});
      a_now = ((k / 10) % 2) == 0;
      applyStimulus(1'b1, 2'b01, {7'b0, a_now}, 8'h00);
      a_hist = {a_hist[1:0], a_now};
      step();
    end
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00);
    step();

    // Both ports pulsed together
    loadButtons(8'h01, 8'h80);
    readSequence("dual", 2'b11, 8'h01, 8'h80, 8);

`ifdef JOYPAD_DPAD_FILTER_EN
    dpad_lr_exp = 8'h03;
    dpad_ud_exp = 8'h03;
`else
    dpad_lr_exp = 8'hC3;
    dpad_ud_exp = 8'h33;
`endif
    // D-pad filter: Left+Right, then Up+Down on port 1
    loadButtons(8'hC3, 8'h00);
    readSequence("dpad_lr", 2'b01, dpad_lr_exp, 8'h00, 8);
    loadButtons(8'h00, 8'h33);
    readSequence("dpad_ud", 2'b10, 8'h00, dpad_ud_exp, 8);
    // Non-opposing Up+Left must pass regardless of the filter
    loadButtons(8'h51, 8'h00);
    readSequence("dpad_legal", 2'b01, 8'h51, 8'h00, 8);

    // Asynchronous reset between the 3rd and 4th pulse
    loadButtons(8'h69, 8'h00);
    readSequence("pre_reset", 2'b01, 8'h69, 8'h00, 3);
    checkOutput("before_reset_bit3", 2'b01);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 2'b00);
    step();
    checkOutput("reset_hold", 2'b00);
    rst = 1'b0;
    loadButtons(8'h69, 8'h00);
    readSequence("post_reset", 2'b01, 8'h69, 8'h00, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
